// File: rtl/toggle_debounce.sv
// Push-button conditioner: two-flop synchronizer, counting debouncer and a press/repeat FSM
// that turns the debounced level into single-cycle toggle pulses for a T flip-flop.
module toggle_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    output logic             t,
    output logic             btn_stable,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    // Counters compare against N-1 so the accepting edge is the N-th one.
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;

    logic             sync1_q, sync_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             stable_q, stable_d;
    state_e           state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             t_q, t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise, fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            db_cnt_q  <= '0;
            stable_q  <= 1'b0;
            state_q   <= StIdle;
            rpt_cnt_q <= '0;
            t_q       <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_in;
            sync_q    <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            stable_q  <= stable_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            t_q       <= t_d;
            cnt_q     <= cnt_d;
        end
    end

    // Any edge where the synchronized level agrees with the accepted one restarts the count.
    always_comb begin
        db_cnt_d = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rise) state_d = StHeld;
            end
            StHeld: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (REPEAT_EN != 0 && rpt_cnt_q == DELAY_LAST) begin
                    state_d = StRepeat;
                end
            end
            StRepeat: begin
                if (fall) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A release edge wins over a repeat pulse falling due on the same edge.
    always_comb begin
        t_d       = 1'b0;
        rpt_cnt_d = '0;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    t_d   = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHeld: begin
                if (!fall && REPEAT_EN != 0) begin
                    if (rpt_cnt_q == DELAY_LAST) begin
                        t_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
            end
            StRepeat: begin
                if (!fall) begin
                    if (rpt_cnt_q == PERIOD_LAST) begin
                        t_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign t           = t_q;
    assign btn_stable  = stable_q;
    assign press_count = cnt_q;

endmodule

// File: tb/tb_toggle_debounce.sv
// Bench for toggle_debounce: three instances (plain, auto-repeat, 2-bit counter) share one
// button and are compared every cycle against a window/arithmetic reference model.
module tb_toggle_debounce;

    localparam int unsigned D      = 4;
    localparam int unsigned DELAY  = 8;
    localparam int unsigned PERIOD = 4;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       t_a, t_b, t_c;
    logic       st_a, st_b, st_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit q_hist[$];
    int m_k;
    bit m_stable;
    int m_rise_k;
    int m_presses;
    bit exp_t_plain;
    bit exp_t_rpt;

    toggle_debounce #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD),
        .CNT_W(8)
    ) u_dut_plain (
        .clk(clk), .reset(reset), .btn_in(btn_in), .t(t_a), .btn_stable(st_a),
        .press_count(cnt_a)
    );

    toggle_debounce #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD),
        .CNT_W(8)
    ) u_dut_rpt (
        .clk(clk), .reset(reset), .btn_in(btn_in), .t(t_b), .btn_stable(st_b),
        .press_count(cnt_b)
    );

    toggle_debounce #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD),
        .CNT_W(2)
    ) u_dut_wrap (
        .clk(clk), .reset(reset), .btn_in(btn_in), .t(t_c), .btn_stable(st_c),
        .press_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit sync_at(input int j);
        return (j >= 3) ? q_hist[j-3] : 1'b0;
    endfunction

    task automatic model_reset();
        q_hist.delete();
        m_k         = 0;
        m_stable    = 1'b0;
        m_rise_k    = 0;
        m_presses   = 0;
        exp_t_plain = 1'b0;
        exp_t_rpt   = 1'b0;
    endtask

    // Stable flips once the last D synchronized samples all disagree with it.
    task automatic model_step();
        bit all_diff;
        bit rise;
        m_k++;
        q_hist.push_back(bit'(btn_in));
        all_diff = 1'b1;
        for (int j = m_k - int'(D) + 1; j <= m_k; j++) begin
            if (sync_at(j) == m_stable) all_diff = 1'b0;
        end
        rise = 1'b0;
        if (all_diff) begin
            m_stable = ~m_stable;
            if (m_stable) begin
                rise      = 1'b1;
                m_rise_k  = m_k;
                m_presses = m_presses + 1;
            end
        end
        exp_t_plain = rise;
        exp_t_rpt   = rise || (m_stable && (m_k - m_rise_k) >= int'(DELAY) &&
                               ((m_k - m_rise_k - int'(DELAY)) % int'(PERIOD)) == 0);
    endtask

    task automatic check_all();
        check("t_plain", 32'(t_a), 32'(exp_t_plain));
        check("t_rpt", 32'(t_b), 32'(exp_t_rpt));
        check("t_wrap", 32'(t_c), 32'(exp_t_plain));
        check("stable_plain", 32'(st_a), 32'(m_stable));
        check("stable_rpt", 32'(st_b), 32'(m_stable));
        check("stable_wrap", 32'(st_c), 32'(m_stable));
        check("count_plain", 32'(cnt_a), 32'(m_presses % 256));
        check("count_rpt", 32'(cnt_b), 32'(m_presses % 256));
        check("count_wrap", 32'(cnt_c), 32'(m_presses % 4));
    endtask

    task automatic cycle(input logic b, input logic r);
        @(negedge clk);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) cycle(b, 1'b1);
    endtask

    initial begin
        logic b;
        reset  = 1'b1;
        btn_in = 1'b0;
        model_reset();
        #2;
        reset  = 1'b0;
        btn_in = 1'b1;
        #1;
        check_all();

        // Button held through reset: debounced as a fresh press after release
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        hold(1'b1, 30);
        hold(1'b0, 12);

        // Bounce, then a settled press
        foreach (q_hist[i]) ;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        hold(1'b1, 14);
        hold(1'b0, 12);

        // Five clean presses walk the 2-bit counter through its wrap
        for (int p = 0; p < 5; p++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end

        // Random runs, mixing long holds with bouncy stretches
        b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            cycle(b, 1'b1);
        end
        hold(1'b0, 12);

        // Async reset while the repeat instance is in its repeat phase
        hold(1'b1, 20);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        hold(1'b1, 14);
        hold(1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
